mac_row_accumulator: RTL and testbench

Downstream stage of the N-lane multiply/adder-tree dot-product unit in the LSTM matrix-vector datapath. The adder tree produces one BIT_WIDTH partial dot product per N-element chunk and carries no valid signal. This block delay-matches the upstream valid/last flags to the tree latency and accumulates the chunks of one matrix row. At row end it adds the bias and emits one saturated BIT_WIDTH pre-activation value for the gate/activation stage.

---
 rtl/mac_row_if.sv | 27 ++
 rtl/mac_row_accumulator.sv | 130 +++++++++++++
 tb/tb_mac_row_accumulator.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_row_if.sv
// mac_row_if: chunk flags, adder-tree result and bias in; row result,
// saturation flag, chunk count and busy out.
interface mac_row_if #(
    parameter int BIT_WIDTH = 18,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_last;
    logic                 flush;
    logic [BIT_WIDTH-1:0] tree_res;
    logic [BIT_WIDTH-1:0] bias;
    logic                 out_valid;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic [CNT_WIDTH-1:0] out_cnt;
    logic                 busy;

    modport master (
        output in_valid, in_last, flush, tree_res, bias,
        input  out_valid, out_data, out_sat, out_cnt, busy
    );

    modport slave (
        input  in_valid, in_last, flush, tree_res, bias,
        output out_valid, out_data, out_sat, out_cnt, busy
    );
endinterface

// File: rtl/mac_row_accumulator.sv
// mac_row_accumulator: aligns chunk flags with the adder tree, sums one
// row of partial dot products, adds bias and saturates to BIT_WIDTH.
module mac_row_accumulator #(
    parameter int BIT_WIDTH = 18,
    parameter int TREE_LAT  = 3,
    parameter int ACC_WIDTH = 26,
    parameter int CNT_WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    mac_row_if.slave io
);
    typedef enum logic {IDLE, ACCUM} state_e;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] OUT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] OUT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    state_e               state_q, state_d;
    logic [TREE_LAT-1:0]  vld_q, vld_d, lst_q, lst_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 row_sat_q, row_sat_d;
    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

    logic                 d_valid, d_last;
    logic [ACC_WIDTH-1:0] sx, bx, base, sum, fin;
    logic [ACC_WIDTH:0]   sum_w, fin_w;
    logic                 sum_ovf, fin_ovf, nar_ovf;
    logic [ACC_WIDTH-BIT_WIDTH:0] hi;
    logic [BIT_WIDTH-1:0] nar;
    logic [CNT_WIDTH-1:0] base_cnt, cnt_inc;

    assign d_valid = vld_q[TREE_LAT-1];
    assign d_last  = lst_q[TREE_LAT-1];

    // One extra bit on each add exposes overflow of the signed ACC range.
    always_comb begin
        sx = {{(ACC_WIDTH-BIT_WIDTH){io.tree_res[BIT_WIDTH-1]}}, io.tree_res};
        bx = {{(ACC_WIDTH-BIT_WIDTH){io.bias[BIT_WIDTH-1]}}, io.bias};
        base     = (state_q == ACCUM) ? acc_q : '0;
        base_cnt = (state_q == ACCUM) ? cnt_q : '0;
        cnt_inc  = (&base_cnt) ? base_cnt : base_cnt + CNT_WIDTH'(1);
        sum_w   = {base[ACC_WIDTH-1], base} + {sx[ACC_WIDTH-1], sx};
        sum_ovf = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
        sum     = sum_ovf ? (sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                          : sum_w[ACC_WIDTH-1:0];
        fin_w   = {sum[ACC_WIDTH-1], sum} + {bx[ACC_WIDTH-1], bx};
        fin_ovf = fin_w[ACC_WIDTH] ^ fin_w[ACC_WIDTH-1];
        fin     = fin_ovf ? (fin_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                          : fin_w[ACC_WIDTH-1:0];
        hi      = fin[ACC_WIDTH-1:BIT_WIDTH-1];
        nar_ovf = (|hi) & ~(&hi);
        nar     = nar_ovf ? (fin[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX)
                          : fin[BIT_WIDTH-1:0];
    end

    always_comb begin
        vld_d[0] = io.in_valid & ~io.flush;
        lst_d[0] = io.in_last;
        for (int i = 1; i < TREE_LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~io.flush;
            lst_d[i] = lst_q[i-1];
        end
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        row_sat_d   = row_sat_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_cnt_d   = out_cnt_q;
        if (io.flush) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            row_sat_d = 1'b0;
        end else if (d_valid && !d_last) begin
            state_d   = ACCUM;
            acc_d     = sum;
            cnt_d     = cnt_inc;
            row_sat_d = row_sat_q | sum_ovf;
        end else if (d_valid && d_last) begin
            out_valid_d = 1'b1;
            out_data_d  = nar;
            out_sat_d   = row_sat_q | sum_ovf | fin_ovf | nar_ovf;
            out_cnt_d   = cnt_inc;
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            row_sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            row_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            row_sat_q   <= row_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_sat   = out_sat_q;
    assign io.out_cnt   = out_cnt_q;
    assign io.busy      = (state_q == ACCUM) | (|vld_q);
endmodule

// File: tb/tb_mac_row_accumulator.sv
// tb_mac_row_accumulator: directed rows from the test plan plus random rows,
// gaps and flushes, checked against a row-level arithmetic model.
module tb_mac_row_accumulator;
    localparam int BW  = 18;
    localparam int LAT = 3;
    localparam int AW  = 26;
    localparam int CW  = 8;

    typedef struct {
        int     due;
        longint data;
        int     sat;
        int     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    longint tree_at[int];
    longint bias_at[int];
    longint row_q[$];
    exp_t   expq[$];
    longint hold_data = 0;
    int     hold_sat = 0;
    int     hold_cnt = 0;

    mac_row_if #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) io();

    mac_row_accumulator #(
        .BIT_WIDTH(BW), .TREE_LAT(LAT), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder-tree stand-in: scheduled results, random junk otherwise.
    always @(posedge clk) begin
        #1;
        io.tree_res = tree_at.exists(cyc) ? BW'(tree_at[cyc]) : BW'($urandom);
        io.bias     = bias_at.exists(cyc) ? BW'(bias_at[cyc]) : BW'($urandom);
    end

    task automatic chk(string tag, longint got, longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    function automatic exp_t model(longint vals[$], longint b, int due);
        longint amax = (longint'(1) << (AW - 1)) - 1;
        longint amin = -(longint'(1) << (AW - 1));
        longint omax = (longint'(1) << (BW - 1)) - 1;
        longint omin = -(longint'(1) << (BW - 1));
        longint acc = 0;
        exp_t   e;
        e.sat = 0;
        foreach (vals[i]) begin
            acc += vals[i];
            if (acc > amax) begin acc = amax; e.sat = 1; end
            if (acc < amin) begin acc = amin; e.sat = 1; end
        end
        acc += b;
        if (acc > amax) begin acc = amax; e.sat = 1; end
        if (acc < amin) begin acc = amin; e.sat = 1; end
        if (acc > omax) begin acc = omax; e.sat = 1; end
        if (acc < omin) begin acc = omin; e.sat = 1; end
        e.data = acc;
        e.cnt  = (vals.size() > 255) ? 255 : vals.size();
        e.due  = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("mon_valid", io.out_valid, 1);
                chk("mon_data", longint'($signed(io.out_data)), expq[0].data);
                chk("mon_sat", io.out_sat, expq[0].sat);
                chk("mon_cnt", io.out_cnt, expq[0].cnt);
                hold_data = expq[0].data;
                hold_sat  = expq[0].sat;
                hold_cnt  = expq[0].cnt;
                void'(expq.pop_front());
            end else begin
                chk("mon_idle_valid", io.out_valid, 0);
                chk("mon_hold_data", longint'($signed(io.out_data)), hold_data);
                chk("mon_hold_sat", io.out_sat, hold_sat);
                chk("mon_hold_cnt", io.out_cnt, hold_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) tick();
    endtask

    task automatic send(longint v, bit last, longint b);
        io.in_valid = 1'b1;
        io.in_last  = last;
        tree_at[cyc + LAT] = v;
        row_q.push_back(v);
        if (last) begin
            bias_at[cyc + LAT] = b;
            expq.push_back(model(row_q, b, cyc + LAT + 1));
            row_q.delete();
        end
        tick();
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
    endtask

    task automatic do_flush();
        io.flush = 1'b1;
        while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
        row_q.delete();
        tick();
        io.flush = 1'b0;
    endtask

    task automatic expect_out(string tag, int t, longint d, int cnt, int sat);
        wait_cyc(t);
        @(negedge clk);
        chk({tag, "_valid"}, io.out_valid, 1);
        chk({tag, "_data"}, longint'($signed(io.out_data)), d);
        chk({tag, "_cnt"}, io.out_cnt, cnt);
        chk({tag, "_sat"}, io.out_sat, sat);
    endtask

    task automatic idle_busy(int n, bit want);
        repeat (n) begin
            @(negedge clk);
            chk("busy", io.busy, longint'(want));
            tick();
        end
    endtask

    task automatic reset_outputs_zero();
        @(negedge clk);
        chk("rst_valid", io.out_valid, 0);
        chk("rst_data", io.out_data, 0);
        chk("rst_sat", io.out_sat, 0);
        chk("rst_cnt", io.out_cnt, 0);
        chk("rst_busy", io.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int n;
        bit fl;
        logic signed [BW-1:0] rv;
        logic signed [BW-1:0] rb;
        longint v;

        rst = 1'b1;
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
        io.flush    = 1'b0;
        reset_outputs_zero();
        tick();
        #2 rst = 1'b0;
        tick();

        send(100, 0, 0);
        send(-30, 0, 0);
        c = cyc;
        send(5, 1, 7);
        expect_out("row3", c + LAT + 1, 82, 3, 0);

        send(131071, 0, 0);
        c = cyc;
        send(131071, 1, 0);
        expect_out("satpos", c + LAT + 1, 131071, 2, 1);
        send(-131072, 0, 0);
        c = cyc;
        send(-131072, 1, -1);
        expect_out("satneg", c + LAT + 1, -131072, 2, 1);

        c = cyc;
        for (int i = 0; i < 4; i++) send(i + 1, 1, 10);
        for (int i = 0; i < 4; i++)
            expect_out("b2b", c + i + LAT + 1, 11 + i, 1, 0);

        send(50, 0, 0);
        idle_busy(5, 1'b1);
        send(60, 0, 0);
        idle_busy(5, 1'b1);
        c = cyc;
        send(70, 1, -80);
        idle_busy(LAT, 1'b1);
        expect_out("gap", c + LAT + 1, 100, 3, 0);
        chk("gap_busy_done", io.busy, 0);

        tick();
        send(1, 0, 0);
        send(2, 0, 0);
        #1 rst = 1'b1;
        expq.delete();
        row_q.delete();
        hold_data = 0;
        hold_sat  = 0;
        hold_cnt  = 0;
        reset_outputs_zero();
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        send(9, 0, 0);
        c = cyc;
        send(1, 1, 0);
        expect_out("postrst", c + LAT + 1, 10, 2, 0);

        tick();
        send(20, 0, 0);
        c = cyc;
        send(30, 1, 0);
        wait_cyc(c + LAT);
        do_flush();
        @(negedge clk);
        chk("flush_valid", io.out_valid, 0);
        chk("flush_busy", io.busy, 0);
        chk("flush_hold", longint'($signed(io.out_data)), 10);
        tick();
        send(3, 0, 0);
        c = cyc;
        send(4, 1, 0);
        expect_out("postflush", c + LAT + 1, 7, 2, 0);

        tick();
        for (int k = 0; k < 260; k++) begin
            c = cyc;
            send(131071, k == 259, 0);
        end
        expect_out("longrow", c + LAT + 1, 131071, 255, 1);

        tick();
        for (int r = 0; r < 80; r++) begin
            n  = $urandom_range(1, 5);
            fl = 1'b0;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                if ($urandom_range(0, 29) == 0) begin
                    do_flush();
                    fl = 1'b1;
                    break;
                end
                rv = BW'($urandom);
                rb = BW'($urandom);
                v  = ($urandom_range(0, 1) == 1) ? longint'(rv)
                                                 : longint'($urandom_range(0, 4000)) - 2000;
                send(v, k == n - 1, longint'(rb));
            end
            if (!fl && $urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, LAT)) tick();
                do_flush();
            end
        end

        c = cyc + 50;
        while (expq.size() > 0 && cyc < c) tick();
        chk("drain_empty", expq.size(), 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
